// File: rtl/breakout_pkg.sv
// Shared types and constants for the breakout brick-hit path.
// Latency: none (declarations and one combinational helper).
// Backpressure: not applicable.
`timescale 1ns/1ps
package breakout_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_LOCK  = 2'd2
  } arb_state_t;

  // Bit positions inside a 4-bit {R,L,D,U} direction nibble.
  localparam int DIR_U = 0;
  localparam int DIR_D = 1;
  localparam int DIR_L = 2;
  localparam int DIR_R = 3;

  // Defaults shared with the column blocks and the score display.
  localparam int NCOL_DEF    = 8;
  localparam int PTS_W_DEF   = 6;
  localparam int SCORE_W_DEF = 10;

  // Opposing directions cannot both move the ball: up beats down, right beats left.
  function automatic logic [3:0] resolve_dir(input logic [3:0] d);
    logic [3:0] m;
    m = d;
    if (d[DIR_U] && d[DIR_D]) m[DIR_D] = 1'b0;
    if (d[DIR_L] && d[DIR_R]) m[DIR_L] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/breakout_hit_arbiter_if.sv
// Bundle between the brick columns / frame timer and the hit arbiter.
// Latency: none (wires only).
// Backpressure: none; columns hold col_req until they see their col_grant pulse.
`timescale 1ns/1ps
interface breakout_hit_arbiter_if
  import breakout_pkg::*;
#(
  parameter int NCOL    = NCOL_DEF,
  parameter int PTS_W   = PTS_W_DEF,
  parameter int SCORE_W = SCORE_W_DEF
);
  logic                    frame_tick;
  logic [NCOL-1:0]         col_req;
  logic [4*NCOL-1:0]       col_dir;
  logic [PTS_W*NCOL-1:0]   col_pts;
  logic [NCOL-1:0]         col_grant;
  logic                    move_u;
  logic                    move_d;
  logic                    move_l;
  logic                    move_r;
  logic [SCORE_W-1:0]      score;
  logic                    busy;

  // Columns and frame timer side.
  modport master (
    output frame_tick, col_req, col_dir, col_pts,
    input  col_grant, move_u, move_d, move_l, move_r, score, busy
  );

  // Arbiter side.
  modport slave (
    input  frame_tick, col_req, col_dir, col_pts,
    output col_grant, move_u, move_d, move_l, move_r, score, busy
  );
endinterface

// File: rtl/breakout_rr_pick.sv
// Round-robin pick: first set request at or above ptr, wrapping modulo NCOL.
// Latency: combinational.
// Backpressure: none; the result follows req/ptr directly.
`timescale 1ns/1ps
module breakout_rr_pick #(
  parameter int NCOL = 8,
  parameter int IW   = (NCOL > 1) ? $clog2(NCOL) : 1
) (
  input  logic [NCOL-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NCOL-1:0] onehot,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [IW-1:0] j;

  // Scan from the farthest slot back toward ptr so the last hit kept is the nearest one.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = '0;
    for (int k = NCOL - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % NCOL);
      if (req[j]) begin
        onehot    = '0;
        onehot[j] = 1'b1;
        idx       = j;
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/breakout_hit_arbiter.sv
// Grants one brick column per bounce (round-robin), pulses ball direction, adds points, then locks out for LOCK_TICKS frames.
// Latency: request seen in IDLE at cycle n -> col_grant/move_* pulse and updated score in cycle n+1.
// Backpressure: requests arriving in GRANT/LOCK are neither granted nor queued; optional counters under BREAKOUT_ARB_HITCNT_EN.
`timescale 1ns/1ps
module breakout_hit_arbiter
  import breakout_pkg::*;
#(
  parameter int NCOL       = NCOL_DEF,
  parameter int PTS_W      = PTS_W_DEF,
  parameter int SCORE_W    = SCORE_W_DEF,
  parameter int LOCK_TICKS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  breakout_hit_arbiter_if.slave bus
`ifdef BREAKOUT_ARB_HITCNT_EN
  ,
  output logic [7:0]            hit_cnt,
  output logic [7:0]            lock_drop
`endif
);

  localparam int IW = (NCOL > 1) ? $clog2(NCOL) : 1;
  localparam int LW = (LOCK_TICKS > 0) ? $clog2(LOCK_TICKS + 1) : 1;

  arb_state_t          state, state_nxt;
  logic [IW-1:0]       rr_ptr;
  logic [LW-1:0]       lock_cnt;

  logic [NCOL-1:0]     pick_onehot;
  logic [IW-1:0]       pick_idx;
  logic                pick_any;

  logic [3:0]          win_dir;
  logic [PTS_W-1:0]    win_pts;
  logic [SCORE_W:0]    score_sum;
  logic [SCORE_W-1:0]  score_sat;
  logic [IW-1:0]       rr_nxt;

  logic [NCOL-1:0]     grant_q;
  logic [3:0]          move_q;
  logic [SCORE_W-1:0]  score_q;
  logic                busy_q;

  breakout_rr_pick #(.NCOL(NCOL), .IW(IW)) u_pick (
    .req    (bus.col_req),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Select the winner's direction nibble and points with a one-hot OR mux.
  always_comb begin
    win_dir = '0;
    win_pts = '0;
    for (int i = 0; i < NCOL; i++) begin
      if (pick_onehot[i]) begin
        win_dir = win_dir | bus.col_dir[4*i +: 4];
        win_pts = win_pts | bus.col_pts[PTS_W*i +: PTS_W];
      end
    end
  end

  // Saturating score add and wrapped pointer advance past the winner.
  always_comb begin
    score_sum = {1'b0, score_q} + {{(SCORE_W + 1 - PTS_W){1'b0}}, win_pts};
    score_sat = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
    rr_nxt    = (pick_idx == IW'(NCOL - 1)) ? '0 : pick_idx + 1'b1;
  end

  // Next-state logic: one GRANT cycle per bounce, optional frame-counted lockout.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE:  if (pick_any) state_nxt = ARB_GRANT;
      ARB_GRANT: state_nxt = (LOCK_TICKS > 0) ? ARB_LOCK : ARB_IDLE;
      ARB_LOCK:  if (bus.frame_tick && (lock_cnt <= LW'(1))) state_nxt = ARB_IDLE;
      default:   state_nxt = ARB_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ARB_IDLE;
    else       state <= state_nxt;
  end

  // Registered outputs, score, pointer and lock counter; pulses default low every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q  <= '0;
      move_q   <= '0;
      score_q  <= '0;
      busy_q   <= 1'b0;
      rr_ptr   <= '0;
      lock_cnt <= '0;
    end else begin
      grant_q <= '0;
      move_q  <= '0;
      busy_q  <= (state_nxt != ARB_IDLE);
      if (state == ARB_IDLE && pick_any) begin
        grant_q <= pick_onehot;
        move_q  <= resolve_dir(win_dir);
        score_q <= score_sat;
        rr_ptr  <= rr_nxt;
      end
      // Loading in GRANT means a frame_tick in that cycle is not counted.
      if (state == ARB_GRANT)
        lock_cnt <= LW'(LOCK_TICKS);
      else if (state == ARB_LOCK && bus.frame_tick && lock_cnt != '0)
        lock_cnt <= lock_cnt - 1'b1;
    end
  end

  assign bus.col_grant = grant_q;
  assign bus.move_u    = move_q[DIR_U];
  assign bus.move_d    = move_q[DIR_D];
  assign bus.move_l    = move_q[DIR_L];
  assign bus.move_r    = move_q[DIR_R];
  assign bus.score     = score_q;
  assign bus.busy      = busy_q;

`ifdef BREAKOUT_ARB_HITCNT_EN
  logic [7:0] hit_q;
  logic [7:0] drop_q;

  // Saturating diagnostics: bounces granted and request-cycles spent locked out.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q  <= '0;
      drop_q <= '0;
    end else begin
      if (state == ARB_GRANT && hit_q != 8'hFF) hit_q <= hit_q + 8'd1;
      if (state == ARB_LOCK && (|bus.col_req) && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end
  end

  assign hit_cnt   = hit_q;
  assign lock_drop = drop_q;
`endif

endmodule

// File: tb/tb_breakout_hit_arbiter.sv
// Directed bench: vector table on a no-lockout instance, hand sequences on a 4-tick-lockout instance.
// Latency: checks outputs 1ns after each rising edge.
// Backpressure: not applicable.
`timescale 1ns/1ps
module tb_breakout_hit_arbiter;
  import breakout_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset0;
  logic reset4;

  breakout_hit_arbiter_if #(.NCOL(8), .PTS_W(6), .SCORE_W(10)) bus0 ();
  breakout_hit_arbiter_if #(.NCOL(8), .PTS_W(6), .SCORE_W(10)) bus4 ();

`ifdef BREAKOUT_ARB_HITCNT_EN
  logic [7:0] hc0, ld0, hc4, ld4;
`endif

  breakout_hit_arbiter #(.NCOL(8), .PTS_W(6), .SCORE_W(10), .LOCK_TICKS(0)) u0 (
    .clk   (clk),
    .reset (reset0),
    .bus   (bus0)
`ifdef BREAKOUT_ARB_HITCNT_EN
    , .hit_cnt (hc0), .lock_drop (ld0)
`endif
  );

  breakout_hit_arbiter #(.NCOL(8), .PTS_W(6), .SCORE_W(10), .LOCK_TICKS(4)) u4 (
    .clk   (clk),
    .reset (reset4),
    .bus   (bus4)
`ifdef BREAKOUT_ARB_HITCNT_EN
    , .hit_cnt (hc4), .lock_drop (ld4)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Requesting column i gets dir and points base+i; idle columns carry decoys.
  task automatic drive0(input logic [7:0] req, input logic [3:0] dir, input logic [5:0] base);
    bus0.col_req = req;
    for (int i = 0; i < 8; i++) begin
      bus0.col_dir[4*i +: 4] = req[i] ? dir : 4'b0110;
      bus0.col_pts[6*i +: 6] = req[i] ? base + 6'(i) : 6'd63;
    end
  endtask

  task automatic drive4(input logic [7:0] req, input logic [3:0] dir, input logic [5:0] pts);
    bus4.col_req = req;
    for (int i = 0; i < 8; i++) begin
      bus4.col_dir[4*i +: 4] = dir;
      bus4.col_pts[6*i +: 6] = pts;
    end
  endtask

  function automatic logic [3:0] mv0();
    return {bus0.move_r, bus0.move_l, bus0.move_d, bus0.move_u};
  endfunction

  function automatic logic [3:0] mv4();
    return {bus4.move_r, bus4.move_l, bus4.move_d, bus4.move_u};
  endfunction

  typedef struct {
    logic [7:0] req;
    logic [3:0] dir;
    logic [5:0] base;
    logic [7:0] g;
    logic [3:0] mv;
    logic [9:0] sc;
    logic       busy;
  } vec_t;

  vec_t vt [16];

  initial begin
    // {req, dir{R,L,D,U}, pts base, exp grant, exp move{R,L,D,U}, exp score, exp busy}
    vt[0]  = '{8'h04, 4'b0010, 6'd5,  8'h04, 4'b0010, 10'd7,  1'b1};
    vt[1]  = '{8'h00, 4'b0000, 6'd0,  8'h00, 4'b0000, 10'd7,  1'b0};
    vt[2]  = '{8'h09, 4'b0001, 6'd2,  8'h08, 4'b0001, 10'd12, 1'b1};
    vt[3]  = '{8'h09, 4'b0001, 6'd2,  8'h00, 4'b0000, 10'd12, 1'b0};
    vt[4]  = '{8'h09, 4'b1000, 6'd2,  8'h01, 4'b1000, 10'd14, 1'b1};
    vt[5]  = '{8'h00, 4'b0000, 6'd0,  8'h00, 4'b0000, 10'd14, 1'b0};
    vt[6]  = '{8'h81, 4'b1111, 6'd1,  8'h80, 4'b1001, 10'd22, 1'b1};
    vt[7]  = '{8'h81, 4'b1111, 6'd1,  8'h00, 4'b0000, 10'd22, 1'b0};
    vt[8]  = '{8'h81, 4'b0011, 6'd1,  8'h01, 4'b0001, 10'd23, 1'b1};
    vt[9]  = '{8'h81, 4'b0011, 6'd1,  8'h00, 4'b0000, 10'd23, 1'b0};
    vt[10] = '{8'h81, 4'b1100, 6'd1,  8'h80, 4'b1000, 10'd31, 1'b1};
    vt[11] = '{8'h00, 4'b0000, 6'd0,  8'h00, 4'b0000, 10'd31, 1'b0};
    vt[12] = '{8'h10, 4'b0000, 6'd20, 8'h10, 4'b0000, 10'd55, 1'b1};
    vt[13] = '{8'h00, 4'b0000, 6'd0,  8'h00, 4'b0000, 10'd55, 1'b0};
    vt[14] = '{8'h20, 4'b0100, 6'd0,  8'h20, 4'b0100, 10'd60, 1'b1};
    vt[15] = '{8'h00, 4'b0000, 6'd0,  8'h00, 4'b0000, 10'd60, 1'b0};

    // Reset with every column requesting: nothing may be granted.
    reset0 = 1'b1;
    reset4 = 1'b1;
    bus0.frame_tick = 1'b0;
    bus4.frame_tick = 1'b0;
    drive0(8'hFF, 4'b1111, 6'd9);
    drive4(8'hFF, 4'b1111, 6'd9);
    step();
    step();
    check("rst_grant0", 32'(bus0.col_grant), 32'h0);
    check("rst_move0",  32'(mv0()),          32'h0);
    check("rst_score0", 32'(bus0.score),     32'h0);
    check("rst_busy0",  32'(bus0.busy),      32'h0);
    check("rst_grant4", 32'(bus4.col_grant), 32'h0);
    check("rst_busy4",  32'(bus4.busy),      32'h0);
    reset0 = 1'b0;
    reset4 = 1'b0;
    drive0(8'h00, 4'b0000, 6'd0);
    drive4(8'h00, 4'b0000, 6'd0);
    step();
    check("post_rst_busy0", 32'(bus0.busy), 32'h0);

    // Table: round-robin order, wrap, conflict resolution, zero direction.
    for (int i = 0; i < 16; i++) begin
      drive0(vt[i].req, vt[i].dir, vt[i].base);
      step();
      check($sformatf("v%0d_grant", i), 32'(bus0.col_grant), 32'(vt[i].g));
      check($sformatf("v%0d_move", i),  32'(mv0()),          32'(vt[i].mv));
      check($sformatf("v%0d_score", i), 32'(bus0.score),     32'(vt[i].sc));
      check($sformatf("v%0d_busy", i),  32'(bus0.busy),      32'(vt[i].busy));
    end

    // Saturation: 60 + 15*63 = 1005, +15 = 1020, +7 -> 1023, +7 -> 1023.
    for (int k = 0; k < 15; k++) begin
      drive0(8'h01, 4'b0001, 6'd63);
      step();
      drive0(8'h00, 4'b0000, 6'd0);
      step();
    end
    check("sat_1005", 32'(bus0.score), 32'd1005);
    drive0(8'h01, 4'b0001, 6'd15);
    step();
    check("sat_1020", 32'(bus0.score), 32'd1020);
    drive0(8'h00, 4'b0000, 6'd0);
    step();
    drive0(8'h01, 4'b0001, 6'd7);
    step();
    check("sat_1023", 32'(bus0.score), 32'd1023);
    check("sat_grant", 32'(bus0.col_grant), 32'h01);
    drive0(8'h00, 4'b0000, 6'd0);
    step();
    drive0(8'h01, 4'b0001, 6'd7);
    step();
    check("sat_hold", 32'(bus0.score), 32'd1023);
    drive0(8'h00, 4'b0000, 6'd0);
    step();

    // Lockout instance: cycle 0 request, cycle 1 grant (tick there is ignored).
    drive4(8'h03, 4'b0010, 6'd3);
    step();
    check("lk_grant1", 32'(bus4.col_grant), 32'h01);
    check("lk_move1",  32'(mv4()),          32'b0010);
    check("lk_score1", 32'(bus4.score),     32'd3);
    bus4.frame_tick = 1'b1;
    step();
    // Cycles 2..9: ticks on even cycles, fourth tick in cycle 8 returns to IDLE in cycle 9.
    for (int k = 2; k <= 9; k++) begin
      check($sformatf("lk_nogrant_c%0d", k), 32'(bus4.col_grant), 32'h0);
      check($sformatf("lk_busy_c%0d", k),    32'(bus4.busy),      (k <= 8) ? 32'd1 : 32'd0);
      bus4.frame_tick = (k % 2 == 0) && (k <= 8);
      step();
    end
    check("lk_grant10", 32'(bus4.col_grant), 32'h02);
    check("lk_score10", 32'(bus4.score),     32'd6);
    check("lk_busy10",  32'(bus4.busy),      32'd1);
    step();
`ifdef BREAKOUT_ARB_HITCNT_EN
    check("hit_cnt", 32'(hc4), 32'd2);
    check("lock_drop", 32'(ld4), 32'd7);
`endif

    // Reset mid-LOCK with a request pending; pointer would otherwise pick column 2.
    drive4(8'h06, 4'b0001, 6'd3);
    step();
    reset4 = 1'b1;
    step();
    check("rst_lock_grant", 32'(bus4.col_grant), 32'h0);
    check("rst_lock_busy",  32'(bus4.busy),      32'h0);
    check("rst_lock_score", 32'(bus4.score),     32'h0);
    reset4 = 1'b0;
    step();
    check("rst_regrant", 32'(bus4.col_grant), 32'h02);
    check("rst_rescore", 32'(bus4.score),     32'd3);
`ifdef BREAKOUT_ARB_HITCNT_EN
    check("rst_hit_cnt", 32'(hc4), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
